// File: rtl/adder_byte_sequencer_if.sv
// Bundles the sequencer's operand request, adder-core and result handshakes.
// Both request and result use valid/ready: a transfer happens on a rising edge
// where valid and ready are both 1; payload must be stable while valid waits.
interface adder_byte_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  // Environment side: operand producer, adder core and result consumer.
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/adder_byte_sequencer.sv
// Wide add built from one external 8-bit adder: operands are fed LSB byte first,
// the carry is chained through a register, and the sum is collected byte by byte.
module adder_byte_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_byte_sequencer_if.slave bus,
  output logic [1:0]            dbg_state
);
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   a_q, a_d;
  logic [NBYTES-1:0][7:0]   b_q, b_d;
  logic [NBYTES-1:0][7:0]   sum_q, sum_d;
  logic                     carry_q, carry_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;

  logic                     in_ready_w;
  logic                     accept_w;
  logic [7:0]               add_a_w;
  logic [7:0]               add_b_w;
  logic                     add_cin_w;

  // in_ready is gated by rst_n so nothing is accepted while reset is held.
  assign in_ready_w = rst_n && (state_q == IDLE);
  assign accept_w   = bus.in_valid && in_ready_w;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    add_a_w   = 8'h00;
    add_b_w   = 8'h00;
    add_cin_w = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_w) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a_w        = a_q[idx_q];
        add_b_w        = b_q[idx_q];
        add_cin_w      = carry_q;
        sum_d[idx_q]   = bus.add_sum;
        carry_d        = bus.add_cout;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: like-signed operands producing an opposite-signed MSB.
          cout_d  = bus.add_cout;
          ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                    (bus.add_sum[7] != a_q[NBYTES-1][7]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.add_a     = add_a_w;
  assign bus.add_b     = add_b_w;
  assign bus.add_cin   = add_cin_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Directed bench for the byte sequencer: a 4-byte and a 1-byte instance, each
// paired with a behavioural 8-bit adder, checked with immediate assertions.
module tb_adder_byte_sequencer;
  logic clk;
  logic rst_n;
  logic [1:0] dbg4, dbg1;

  int passed = 0;
  int total  = 0;

  logic [7:0] cin_seen [4];
  logic [7:0] sum_seen [4];

  adder_byte_sequencer_if #(.NBYTES(4)) bus4 ();
  adder_byte_sequencer_if #(.NBYTES(1)) bus1 ();

  adder_byte_sequencer #(.NBYTES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4.slave),
    .dbg_state (dbg4)
  );

  adder_byte_sequencer #(.NBYTES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  // Behavioural 8-bit adder cores.
  assign {bus4.add_cout, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {8'h00, bus4.add_cin};
  assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'h00, bus1.add_cin};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 4-byte operation, checks each RUN cycle and the result, then
  // leaves the DUT in DONE with out_ready low.
  task automatic do_op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] es, input logic ec, input logic eo);
    check({tag, " in_ready before accept"}, 64'(bus4.in_ready), 64'(1));
    bus4.in_valid = 1'b1;
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_cin   = cin;
    step();
    bus4.in_valid = 1'b0;
    bus4.in_a     = 32'h0;
    bus4.in_b     = 32'h0;
    bus4.in_cin   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, " run add_a"}, 64'(bus4.add_a), 64'(a[8*k +: 8]));
      check({tag, " run add_b"}, 64'(bus4.add_b), 64'(b[8*k +: 8]));
      check({tag, " run out_valid"}, 64'(bus4.out_valid), 64'(0));
      cin_seen[k] = {7'h0, bus4.add_cin};
      sum_seen[k] = bus4.add_sum;
      step();
    end
    check({tag, " out_valid"}, 64'(bus4.out_valid), 64'(1));
    check({tag, " out_sum"},   64'(bus4.out_sum),   64'(es));
    check({tag, " out_cout"},  64'(bus4.out_cout),  64'(ec));
    check({tag, " out_ovf"},   64'(bus4.out_ovf),   64'(eo));
    check({tag, " in_ready in done"}, 64'(bus4.in_ready), 64'(0));
  endtask

  task automatic release4(input string tag);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check({tag, " release out_valid"}, 64'(bus4.out_valid), 64'(0));
    check({tag, " release in_ready"},  64'(bus4.in_ready),  64'(1));
  endtask

  initial begin
    logic [31:0] held_sum;
    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_a      = 32'h0;
    bus4.in_b      = 32'h0;
    bus4.in_cin    = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = 8'h0;
    bus1.in_b      = 8'h0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;

    // Test 1: reset then a plain add
    repeat (3) step();
    check("rst in_ready",  64'(bus4.in_ready),  64'(0));
    check("rst out_valid", 64'(bus4.out_valid), 64'(0));
    check("rst out_sum",   64'(bus4.out_sum),   64'(0));
    check("rst out_cout",  64'(bus4.out_cout),  64'(0));
    check("rst out_ovf",   64'(bus4.out_ovf),   64'(0));
    check("rst state",     64'(dbg4),           64'(0));
    rst_n = 1'b1;
    #1;
    do_op4("t1", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
    release4("t1");

    // Test 2: carry ripples through every byte
    do_op4("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("t2 add_cin", 64'(cin_seen[k]), 64'(1));
      check("t2 add_sum", 64'(sum_seen[k]), 64'(0));
    end
    release4("t2");

    // Test 3: signed overflow both directions
    do_op4("t3a", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    release4("t3a");
    do_op4("t3b", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    release4("t3b");

    // Test 4: stall in DONE while new operands are offered
    do_op4("t4", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus4.in_a = 32'hA5A50000 + 32'(k);
      bus4.in_b = 32'h01010101;
      step();
      check("t4 stall out_valid", 64'(bus4.out_valid), 64'(1));
      check("t4 stall out_sum",   64'(bus4.out_sum),   64'(32'h00000100));
      check("t4 stall in_ready",  64'(bus4.in_ready),  64'(0));
    end
    bus4.in_valid = 1'b0;
    release4("t4");
    check("t4 idle out_sum held", 64'(bus4.out_sum), 64'(32'h00000100));
    step();
    check("t4 idle state", 64'(dbg4), 64'(0));

    // Test 5: reset during the second RUN cycle
    bus4.in_valid = 1'b1;
    bus4.in_a     = 32'h01020304;
    bus4.in_b     = 32'h10203040;
    step();
    bus4.in_valid = 1'b0;
    step();
    check("t5 second run state", 64'(dbg4), 64'(1));
    rst_n = 1'b0;
    step();
    check("t5 rst out_valid", 64'(bus4.out_valid), 64'(0));
    check("t5 rst add_a",     64'(bus4.add_a),     64'(0));
    check("t5 rst add_b",     64'(bus4.add_b),     64'(0));
    check("t5 rst add_cin",   64'(bus4.add_cin),   64'(0));
    check("t5 rst out_sum",   64'(bus4.out_sum),   64'(0));
    check("t5 rst in_ready",  64'(bus4.in_ready),  64'(0));
    rst_n = 1'b1;
    #1;
    check("t5 release in_ready", 64'(bus4.in_ready), 64'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5 no stray out_valid", 64'(bus4.out_valid), 64'(0));
    end
    do_op4("t5", 32'hDEADBEEF, 32'h01010101, 1'b1, 32'hDFAEBFF1, 1'b0, 1'b0);
    release4("t5");

    // Test 6: single-byte instance
    check("t6 in_ready", 64'(bus1.in_ready), 64'(1));
    bus1.in_valid = 1'b1;
    bus1.in_a     = 8'hF0;
    bus1.in_b     = 8'h20;
    bus1.in_cin   = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    check("t6 run state",     64'(dbg1),           64'(1));
    check("t6 run add_a",     64'(bus1.add_a),     64'(8'hF0));
    check("t6 run add_cin",   64'(bus1.add_cin),   64'(1));
    check("t6 run out_valid", 64'(bus1.out_valid), 64'(0));
    step();
    check("t6 out_valid", 64'(bus1.out_valid), 64'(1));
    check("t6 out_sum",   64'(bus1.out_sum),   64'(8'h11));
    check("t6 out_cout",  64'(bus1.out_cout),  64'(1));
    check("t6 out_ovf",   64'(bus1.out_ovf),   64'(0));
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("t6 release out_valid", 64'(bus1.out_valid), 64'(0));
    check("t6 release in_ready",  64'(bus1.in_ready),  64'(1));

    // Report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
